// File: rtl/four_bit_adder_sync_pkg.sv
// Purpose: shared width constant and operand type for the registered nibble adder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package four_bit_adder_sync_pkg;

    localparam int ADDER_WIDTH = 4;

    typedef logic [ADDER_WIDTH-1:0] nibble_t;

endpackage : four_bit_adder_sync_pkg

// File: rtl/four_bit_adder_sync_full_adder.sv
// Purpose: single-bit full adder, one link of the ripple carry chain.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    // Sum bit and majority carry for this bit position.
    always_comb begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule : full_adder

// File: rtl/four_bit_adder_sync.sv
// Purpose: registered WIDTH-bit ripple adder with carry in/out and signed overflow.
// Latency: 1 cycle from in_valid sample to out_valid; one result per cycle.
// Backpressure: none; a new operation is accepted on every cycle in_valid is high.
module four_bit_adder_sync
    import four_bit_adder_sync_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             out_valid
);

    // carry[i] is the carry into bit i; carry[WIDTH] is the carry out of the MSB.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic             ovf_d;

    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             vld_q;

    assign carry[0] = cin;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_fa
            full_adder u_fa (
                .a    (a[i]),
                .b    (b[i]),
                .cin  (carry[i]),
                .s    (sum_d[i]),
                .cout (carry[i+1])
            );
        end
    endgenerate

    // Overflow when the carry into the sign bit differs from the carry out of it.
    always_comb begin
        cout_d = carry[WIDTH];
        ovf_d  = carry[WIDTH] ^ carry[WIDTH-1];
    end

    // Result registers load only on a valid sample; reset wins over in_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (in_valid) begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
        end
    end

    // Valid flag pulses for exactly the cycle following each accepted operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= 1'b0;
        end else begin
            vld_q <= in_valid;
        end
    end

    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign out_valid = vld_q;

endmodule : four_bit_adder_sync

// File: tb/tb_four_bit_adder_sync.sv
// Purpose: directed and exhaustive self-checking bench for the registered nibble adder.
// Latency: expects results one clock after each sampled operation.
// Backpressure: none exercised; stimulus runs at full rate.
module tb_four_bit_adder_sync;
    import four_bit_adder_sync_pkg::*;

    logic    clk = 1'b0;
    logic    rst;
    nibble_t a;
    nibble_t b;
    logic    cin;
    logic    in_valid;
    nibble_t sum;
    logic    cout;
    logic    ovf;
    logic    out_valid;

    int pass_cnt  = 0;
    int total_cnt = 0;

    four_bit_adder_sync #(.WIDTH(ADDER_WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .in_valid  (in_valid),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Drive inputs on the falling edge, let one rising edge capture them,
    // and return on the next falling edge where the outputs are sampled.
    task automatic apply(input logic [3:0] va, input logic [3:0] vb, input logic vc,
                         input logic vv, input logic vr);
        a        = va;
        b        = vb;
        cin      = vc;
        in_valid = vv;
        rst      = vr;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_all(input string tag, input logic [3:0] es, input logic ec,
                           input logic eo, input logic ev);
        chk({tag, ".sum"},       32'(sum),       32'(es));
        chk({tag, ".cout"},      32'(cout),      32'(ec));
        chk({tag, ".ovf"},       32'(ovf),       32'(eo));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
    endtask

    logic [3:0] ra [8];
    logic [3:0] rb [8];
    logic       rc [8];
    logic [4:0] ref_full;
    logic       ref_ovf;

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
        @(negedge clk);

        // Reset held two cycles with a live operation that must be dropped.
        apply(4'd9, 4'd9, 1'b0, 1'b1, 1'b1);
        chk_all("reset1", 4'd0, 1'b0, 1'b0, 1'b0);
        apply(4'd9, 4'd9, 1'b0, 1'b1, 1'b1);
        chk_all("reset2", 4'd0, 1'b0, 1'b0, 1'b0);

        // First cycle out of reset with no valid input.
        apply(4'd9, 4'd9, 1'b0, 1'b0, 1'b0);
        chk_all("post_reset_idle", 4'd0, 1'b0, 1'b0, 1'b0);

        // Directed vectors with hand-computed results.
        apply(4'd0,  4'd0,  1'b0, 1'b1, 1'b0); chk_all("v_0_0_0",   4'd0,  1'b0, 1'b0, 1'b1);
        apply(4'd15, 4'd15, 1'b0, 1'b1, 1'b0); chk_all("v_15_15_0", 4'd14, 1'b1, 1'b0, 1'b1);
        apply(4'd15, 4'd15, 1'b1, 1'b1, 1'b0); chk_all("v_15_15_1", 4'd15, 1'b1, 1'b0, 1'b1);
        apply(4'd9,  4'd10, 1'b1, 1'b1, 1'b0); chk_all("v_9_10_1",  4'd4,  1'b1, 1'b1, 1'b1);
        apply(4'd7,  4'd9,  1'b0, 1'b1, 1'b0); chk_all("v_7_9_0",   4'd0,  1'b1, 1'b0, 1'b1);
        apply(4'd15, 4'd0,  1'b1, 1'b1, 1'b0); chk_all("v_15_0_1",  4'd0,  1'b1, 1'b0, 1'b1);
        apply(4'd7,  4'd1,  1'b0, 1'b1, 1'b0); chk_all("ovf_7_1_0", 4'd8,  1'b0, 1'b1, 1'b1);

        // Hold: one valid 3+4 then idle cycles with different operands present.
        apply(4'd3, 4'd4, 1'b0, 1'b1, 1'b0);
        chk_all("hold_load", 4'd7, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            apply(4'd15, 4'd15, 1'b1, 1'b0, 1'b0);
            chk_all($sformatf("hold%0d", k), 4'd7, 1'b0, 1'b0, 1'b0);
        end

        // Streaming random vectors with reset on the fifth.
        for (int k = 0; k < 8; k++) begin
            ra[k] = 4'($urandom_range(0, 15));
            rb[k] = 4'($urandom_range(0, 15));
            rc[k] = 1'($urandom_range(0, 1));
        end
        for (int k = 0; k < 8; k++) begin
            apply(ra[k], rb[k], rc[k], 1'b1, (k == 4));
            ref_full = 5'(ra[k]) + 5'(rb[k]) + 5'(rc[k]);
            ref_ovf  = (ra[k][3] == rb[k][3]) && (ref_full[3] != ra[k][3]);
            if (k == 4)
                chk_all($sformatf("stream%0d_rst", k), 4'd0, 1'b0, 1'b0, 1'b0);
            else
                chk_all($sformatf("stream%0d", k), ref_full[3:0], ref_full[4], ref_ovf, 1'b1);
        end

        // Exhaustive sweep at full rate.
        for (int v = 0; v < 512; v++) begin
            logic [3:0] ea;
            logic [3:0] eb;
            logic       ec;
            ea = 4'(v >> 5);
            eb = 4'(v >> 1);
            ec = 1'(v);
            apply(ea, eb, ec, 1'b1, 1'b0);
            ref_full = 5'(ea) + 5'(eb) + 5'(ec);
            ref_ovf  = (ea[3] == eb[3]) && (ref_full[3] != ea[3]);
            chk($sformatf("exh_%0d_%0d_%0d.full", ea, eb, ec), 32'({cout, sum}), 32'(ref_full));
            chk($sformatf("exh_%0d_%0d_%0d.ovf", ea, eb, ec), 32'(ovf), 32'(ref_ovf));
            chk($sformatf("exh_%0d_%0d_%0d.vld", ea, eb, ec), 32'(out_valid), 32'd1);
        end

        apply(4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("final_idle.out_valid", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_four_bit_adder_sync
